uart_write_scheduler: RTL and testbench

//  Collects console writes from the 3-wide RV32IM issue lanes and serialises them onto one UART.
//  Up to LANES byte stores to the UART MMIO address can retire in one cycle. The block queues

---
 rtl/rv32im_pkg.sv | 11 +
 rtl/uart_tx_fifo.sv | 43 ++++
 rtl/uart_write_scheduler.sv | 120 ++++++++++++
 tb/tb_uart_write_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// rv32im_pkg: shared constants and UART transmitter state encoding
package rv32im_pkg;
  localparam logic [31:0] UART_ADDR = 32'h1000_0000;
  localparam int UART_OUT_W = 9;
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: sync byte FIFO with LANES compacted write ports and one read port
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_push_n         : number of bytes to write this cycle (caller guarantees room)
//   i_push_data      : compacted bytes, slot k at [8k+7:8k], slots below i_push_n valid
//   i_pop            : dequeue the head byte (caller guarantees non-empty)
//   o_rd_data        : head byte
//   o_count          : registered occupancy
module uart_tx_fifo
  import rv32im_pkg::*;
#(
  parameter int LANES = 3,
  parameter int DEPTH = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [$clog2(LANES+1)-1:0]   i_push_n,
  input  logic [8*LANES-1:0]           i_push_data,
  input  logic                         i_pop,
  output logic [7:0]                   o_rd_data,
  output logic [$clog2(DEPTH):0]       o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int k = 0; k < LANES; k++)
        if (k < int'(i_push_n)) r_mem[r_wr_ptr + PW'(k)] <= i_push_data[8*k +: 8];
      r_wr_ptr <= r_wr_ptr + PW'(i_push_n);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
      r_count  <= r_count + CW'(i_push_n) - CW'(i_pop);
    end
  end
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
endmodule

// File: rtl/uart_write_scheduler.sv
// uart_write_scheduler: queues multi-lane console byte stores and drains them one byte at a time
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_wr_valid       : per-lane byte store retiring this cycle
//   i_wr_data        : lane i byte at [8i+7:8i]
//   o_stall          : no lane accepted this cycle, retire must hold
//   o_uart_out       : [8] one-cycle dequeue strobe, [7:0] last dequeued byte
//   o_tx             : 8N1 serial line when UART_SERIAL_EN is defined, else constant 1
//   o_busy           : FIFO non-empty or transmitter active
module uart_write_scheduler
  import rv32im_pkg::*;
#(
  parameter int LANES        = 3,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [LANES-1:0]      i_wr_valid,
  input  logic [8*LANES-1:0]    i_wr_data,
  output logic                  o_stall,
  output logic [UART_OUT_W-1:0] o_uart_out,
  output logic                  o_tx,
  output logic                  o_busy
);
  localparam int NW = $clog2(LANES + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  if (CLKS_PER_BIT < 1 || DEPTH < LANES || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_write_scheduler: invalid LANES/DEPTH/CLKS_PER_BIT");
  end
  logic [NW-1:0]         w_n;
  logic [8*LANES-1:0]    w_comp;
  logic [CW-1:0]         w_count;
  logic [7:0]            w_rd_data;
  logic                  w_ready;
  logic                  w_pop;
  logic [UART_OUT_W-1:0] r_uart_out;
  // Valid lanes are packed into consecutive slots, oldest lane first
  always_comb begin
    w_n    = '0;
    w_comp = '0;
    for (int i = 0; i < LANES; i++)
      if (i_wr_valid[i]) begin
        w_comp[8*w_n +: 8] = i_wr_data[8*i +: 8];
        w_n = w_n + NW'(1);
      end
  end
  // Credit comes from the registered count only; a same-cycle pop does not free a slot
  assign o_stall = int'(w_n) > DEPTH - int'(w_count);
  assign w_pop   = (w_count != '0) && w_ready;
  uart_tx_fifo #(.LANES(LANES), .DEPTH(DEPTH)) u_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push_n    (o_stall ? '0 : w_n),
    .i_push_data (w_comp),
    .i_pop       (w_pop),
    .o_rd_data   (w_rd_data),
    .o_count     (w_count)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset) r_uart_out <= '0;
    else r_uart_out <= w_pop ? {1'b1, w_rd_data} : {1'b0, r_uart_out[7:0]};
  end
  assign o_uart_out = r_uart_out;
`ifdef UART_SERIAL_EN
  localparam int DW = $clog2(CLKS_PER_BIT + 1);
  tx_state_t r_state, w_state_nx;
  logic [DW-1:0] r_div, w_div_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          w_div_end;
  assign w_div_end = r_div == DW'(CLKS_PER_BIT - 1);
  assign w_ready   = r_state == TX_IDLE;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= TX_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = (r_state == TX_IDLE || w_div_end) ? '0 : r_div + DW'(1);
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    case (r_state)
      TX_IDLE:
        if (w_pop) begin
          w_state_nx = TX_START;
          w_shift_nx = w_rd_data;
        end
      TX_START:
        if (w_div_end) begin
          w_state_nx = TX_DATA;
          w_bit_nx   = '0;
        end
      TX_DATA:
        if (w_div_end) begin
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_bit_nx   = r_bit + 3'd1;
          w_state_nx = r_bit == 3'd7 ? TX_STOP : TX_DATA;
        end
      TX_STOP:
        if (w_div_end) w_state_nx = TX_IDLE;
      default: w_state_nx = TX_IDLE;
    endcase
  end
  assign o_tx   = r_state == TX_START ? 1'b0 : r_state == TX_DATA ? r_shift[0] : 1'b1;
  assign o_busy = (w_count != '0) || (r_state != TX_IDLE);
`else
  assign w_ready = 1'b1;
  assign o_tx    = 1'b1;
  assign o_busy  = w_count != '0;
`endif
endmodule

// File: tb/tb_uart_write_scheduler.sv
// tb_uart_write_scheduler: randomized scoreboard bench for uart_write_scheduler
module tb_uart_write_scheduler;
  localparam int LANES = 3;
  localparam int DEPTH = 8;
  localparam int P     = 4;
`ifdef UART_SERIAL_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif
  typedef struct {
    int         c;
    logic [7:0] b;
  } exp_t;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [2:0]  i_wr_valid = '0;
  logic [23:0] i_wr_data = '0;
  logic        o_stall;
  logic [8:0]  o_uart_out;
  logic        o_tx;
  logic        o_busy;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  m_fifo[$];
  exp_t        sb[$];
  int          last_pop = -1;
  logic [7:0]  tx_byte = '0;
  logic [7:0]  last_byte = '0;
  uart_write_scheduler #(.LANES(LANES), .DEPTH(DEPTH), .CLKS_PER_BIT(P)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_stall    (o_stall),
    .o_uart_out (o_uart_out),
    .o_tx       (o_tx),
    .o_busy     (o_busy)
  );
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endfunction
  // Frame timeline relative to the pop cycle: start bit, 8 data bits LSB first, stop bit
  function automatic logic exp_tx();
    int d;
    d = cyc - last_pop;
    if (!SERIAL || last_pop < 0 || d < 1 || d > 10*P) return 1'b1;
    if (d <= P) return 1'b0;
    if (d <= 9*P) return tx_byte[(d-P-1)/P];
    return 1'b1;
  endfunction
  function automatic logic exp_busy();
    int d;
    d = cyc - last_pop;
    return (m_fifo.size() != 0) || (SERIAL && last_pop >= 0 && d >= 1 && d <= 10*P);
  endfunction
  task automatic step(input logic [2:0] v, input logic [23:0] d, input bit rst, output bit acc);
    bit es, ready;
    logic [7:0] b;
    @(posedge i_clock);
    #1;
    i_reset    = rst;
    i_wr_valid = v;
    i_wr_data  = d;
    @(negedge i_clock);
    es = $countones(v) > DEPTH - m_fifo.size();
    chk("stall", 32'(o_stall), 32'(es));
    chk("tx", 32'(o_tx), 32'(exp_tx()));
    chk("busy", 32'(o_busy), 32'(exp_busy()));
    acc = 1'b0;
    if (rst) begin
      m_fifo.delete();
      sb.delete();
      last_pop  = -1;
      last_byte = '0;
      return;
    end
    ready = !SERIAL || last_pop < 0 || (cyc - last_pop) >= 10*P + 1;
    if (m_fifo.size() != 0 && ready) begin
      b = m_fifo.pop_front();
      sb.push_back('{cyc + 1, b});
      last_pop = cyc;
      tx_byte  = b;
    end
    if (!es) begin
      acc = 1'b1;
      for (int i = 0; i < LANES; i++) if (v[i]) m_fifo.push_back(d[8*i +: 8]);
    end
  endtask
  always @(posedge i_clock) begin
    #3;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].c == cyc) begin
        chk("strobe", 32'(o_uart_out[8]), 32'd1);
        chk("byte", 32'(o_uart_out[7:0]), 32'(sb[0].b));
        last_byte = sb[0].b;
        void'(sb.pop_front());
      end else begin
        chk("no_strobe", 32'(o_uart_out[8]), 32'd0);
        chk("held", 32'(o_uart_out[7:0]), 32'(last_byte));
      end
    end
  end
  task automatic rand_phase(input int n, input bit sparse);
    bit acc = 1'b1;
    logic [2:0] v = '0;
    logic [23:0] d = '0;
    for (int i = 0; i < n; i++) begin
      if (acc) begin
        v = 3'($urandom_range(0, 7));
        d = 24'($urandom);
        if (sparse && $urandom_range(0, 3) != 0) v = '0;
      end
      step(v, d, 1'b0, acc);
    end
  endtask
  initial begin
    bit acc;
    bit mid;
    repeat (3) @(posedge i_clock);
    mon_en = 1'b1;
    step(3'b111, {8'h43, 8'h42, 8'h41}, 1'b0, acc);
    step(3'b101, {8'h33, 8'h99, 8'h31}, 1'b0, acc);
    step(3'b001, {16'h0, 8'h55}, 1'b0, acc);
    repeat (4) step(3'b000, 24'h0, 1'b0, acc);
    for (int i = 0; i < 12; i++) step(3'b111, {8'(3*i+2), 8'(3*i+1), 8'(3*i)}, 1'b0, acc);
    rand_phase(SERIAL ? 600 : 400, 1'b0);
    rand_phase(SERIAL ? 600 : 300, 1'b1);
    step(3'b111, 24'hA5C3E1, 1'b0, acc);
    mid = !SERIAL;
    for (int k = 0; k < 200 && !mid; k++) begin
      step(3'b000, 24'h0, 1'b0, acc);
      mid = last_pop >= 0 && (cyc - last_pop) == P + 8;
    end
    if (SERIAL) chk("reach_mid_data", 32'(mid), 32'd1);
    step(3'b000, 24'h0, 1'b1, acc);
    repeat (3) step(3'b000, 24'h0, 1'b0, acc);
    rand_phase(SERIAL ? 400 : 200, 1'b0);
    for (int k = 0; k < 3000 && (m_fifo.size() != 0 || sb.size() != 0); k++)
      step(3'b000, 24'h0, 1'b0, acc);
    step(3'b000, 24'h0, 1'b0, acc);
    chk("drained", 32'(m_fifo.size() + sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
